// File: rtl/delay_pkg.sv
// ---------------------------------------------------------------------------
// delay_pkg
// Shared definitions for the delay_count_sampler slice.
//   DELAY_W  : default width of the sampled counter value and of each delta
//   state_t  : sampler state (S_IDLE = no previous sample, S_ARMED = have one)
//   clog2    : ceiling log2, used to size pointers and the occupancy count
// ---------------------------------------------------------------------------
package delay_pkg;

    localparam int DELAY_W = 32;

    // Explicit 1-bit encoding so the state maps directly onto io_armed.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time sizing: clog2(4)=2, clog2(5)=3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/delay_sample_fifo.sv
// ---------------------------------------------------------------------------
// delay_sample_fifo
// Small synchronous FIFO holding the measured deltas.
//   clk      in   sole clock
//   i_rst_n  in   synchronous active-low reset (pointers and count to 0)
//   i_push   in   write request; accepted when not full, or when full and a
//                 pop happens in the same cycle
//   i_data   in   WIDTH-bit entry to write
//   i_pop    in   read request; ignored while empty
//   o_data   out  head entry (registered storage, meaningful when !o_empty)
//   o_full   out  occupancy == DEPTH
//   o_empty  out  occupancy == 0
//   o_count  out  occupancy, clog2(DEPTH+1) bits
// Pointers are clog2(DEPTH) bits and wrap on their own because DEPTH is a
// power of two; the separate count tells full from empty.
// ---------------------------------------------------------------------------
module delay_sample_fifo
    import delay_pkg::*;
#(
    parameter  int WIDTH = DELAY_W,
    parameter  int DEPTH = 4,
    localparam int PW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A pop on a full FIFO frees the slot the concurrent push writes into.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (i_rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/delay_count_sampler.sv
// ---------------------------------------------------------------------------
// delay_count_sampler
// Samples an upstream free-running counter on each trigger and queues the
// modular delta since the previous sample, measuring inter-event intervals.
//   clk           in   sole clock
//   reset         in   synchronous active-low reset; overrides everything
//   io_in         in   WIDTH-bit counter value
//   io_trig       in   sample request for this cycle
//   io_out_valid  out  head delta available
//   io_out_ready  in   consumer takes the head this cycle
//   io_out_bits   out  head delta
//   io_count      out  FIFO occupancy
//   io_armed      out  a previous sample is held (sampler state)
//   io_overflow   out  sticky: a delta was dropped on a full FIFO
//
// Output handshake: an entry transfers at a posedge where io_out_valid and
// io_out_ready are both 1; io_out_valid never depends on io_out_ready, and
// io_out_bits/io_out_valid hold steady until that transfer edge.
//
// All outputs come from registers; io_in and io_trig only reach state.
// ---------------------------------------------------------------------------
module delay_count_sampler
    import delay_pkg::*;
#(
    parameter  int WIDTH = DELAY_W,
    parameter  int DEPTH = 4,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    input  logic             io_trig,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_bits,
    output logic [CW-1:0]    io_count,
    output logic             io_armed,
    output logic             io_overflow
);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic             r_overflow;

    logic [WIDTH-1:0] w_delta;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    // Unsigned subtraction wraps modulo 2^WIDTH, so a counter rollover
    // between samples still yields the true tick distance.
    assign w_delta = io_in - r_prev;

    // Only an armed sampler has a reference sample to measure against.
    assign w_push = io_trig && (r_state == S_ARMED);
    assign w_pop  = !w_empty && io_out_ready;

    // Full with no concurrent pop: the delta is lost.
    assign w_drop = w_push && w_full && !w_pop;

    delay_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_delta),
        .i_pop   (w_pop),
        .o_data  (io_out_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (io_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_prev     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (io_trig) begin
                // The reference moves on every trigger, even when the delta
                // is dropped, so the next delta measures from this sample.
                r_prev <= io_in;
                case (r_state)
                    S_IDLE:  r_state <= S_ARMED;
                    S_ARMED: r_state <= S_ARMED;
                    default: r_state <= S_IDLE;
                endcase
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign io_out_valid = !w_empty;
    assign io_armed     = (r_state == S_ARMED);
    assign io_overflow  = r_overflow;

endmodule
